// File: rtl/uart_ctrl_pkg.sv
// Shared types and frame constants for the uart_ctrl 8N1 controller.
`timescale 1ns/1ps
package uart_ctrl_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

  // Integer-truncated bit cell length in system clocks.
  function automatic int calc_clks_per_bit(input int clk_freq_hz, input int baud);
    return clk_freq_hz / baud;
  endfunction

endpackage

// File: rtl/uart_ctrl_rx.sv
// 8N1 receiver: 2-flop synchronizer, start validation, mid-cell sampling and
// stop-bit framing check. byte_vld pulses for one cycle per good byte.
`timescale 1ns/1ps
module uart_ctrl_rx
  import uart_ctrl_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 byte_vld,
  output logic [DATA_BITS-1:0] byte_data
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);

  rx_state_e              state_q, state_d;
  logic                   rx_p0, rx_p1, rx_p2;
  logic                   fill_p0, fill_p1;
  logic                   armed_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [2:0]             bit_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   sample;
  logic                   start_edge;

  // Synchronizer; armed only once a real (post-reset) high has been seen,
  // so a line held low out of reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0   <= 1'b1;
      rx_p1   <= 1'b1;
      rx_p2   <= 1'b1;
      fill_p0 <= 1'b0;
      fill_p1 <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      rx_p0   <= rx;
      rx_p1   <= rx_p0;
      rx_p2   <= rx_p1;
      fill_p0 <= 1'b1;
      fill_p1 <= fill_p0;
      armed_q <= armed_q | (fill_p1 & rx_p1);
    end
  end

  assign start_edge = armed_q & rx_p2 & ~rx_p1;

  always_comb begin
    sample = 1'b0;
    case (state_q)
      RX_START:         sample = (cnt_q == HALF_LAST);
      RX_DATA, RX_STOP: sample = (cnt_q == CNT_LAST);
      default:          ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:      if (start_edge) state_d = RX_START;
      RX_START:     if (sample) state_d = rx_p1 ? RX_IDLE : RX_DATA;
      RX_DATA:      if (sample && bit_q == DATA_LAST) state_d = RX_STOP;
      RX_STOP:      if (sample) state_d = rx_p1 ? RX_IDLE : RX_WAIT_IDLE;
      RX_WAIT_IDLE: if (rx_p1) state_d = RX_IDLE;
      default:      state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    byte_vld = (state_q == RX_STOP) && sample && rx_p1;
  end

  // Cell timing: counter restarts at every sample point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      bit_q <= '0;
    end else begin
      if (state_q == RX_IDLE || sample) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_q != RX_DATA) begin
        bit_q <= '0;
      end else if (sample) begin
        bit_q <= bit_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == RX_DATA && sample) begin
      shift_q <= {rx_p1, shift_q[DATA_BITS-1:1]};
    end
  end

  assign byte_data = shift_q;

endmodule

// File: rtl/uart_ctrl.sv
// Full-duplex 8N1 UART controller: TX FSM + host handshakes, RX in uart_ctrl_rx.
// Optional macro UART_CTRL_OVERRUN_FLAG_EN adds the RX_OVERRUN sticky flag.
`timescale 1ns/1ps
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic       RXDATA_READY,
  input  logic       RXDATA_RETRIEVED,
  output logic [7:0] RXDATA,
  output logic       TX,
  input  logic [7:0] TXDATA,
  input  logic       TXCAPTURE,
  input  logic       TXTRANSMIT,
  output logic       TXSENT
`ifdef UART_CTRL_OVERRUN_FLAG_EN
  ,
  output logic       RX_OVERRUN
`endif
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  tx_state_e            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q;
  logic [2:0]           tx_bit_q;
  logic [DATA_BITS-1:0] tx_hold_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_cell_done;
  logic                 tx_accept;

  logic                 rx_byte_vld;
  logic [DATA_BITS-1:0] rx_byte;

  assign tx_cell_done = (tx_cnt_q == CNT_LAST);
  assign tx_accept    = (tx_state_q == TX_IDLE) && TXTRANSMIT;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_state_q <= TX_IDLE;
    end else begin
      tx_state_q <= tx_state_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE:  if (TXTRANSMIT) tx_state_d = TX_START;
      TX_START: if (tx_cell_done) tx_state_d = TX_DATA;
      TX_DATA:  if (tx_cell_done && tx_bit_q == DATA_LAST) tx_state_d = TX_STOP;
      TX_STOP:  if (tx_cell_done && tx_bit_q == STOP_LAST) tx_state_d = TX_IDLE;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    TX     = 1'b1;
    TXSENT = 1'b0;
    case (tx_state_q)
      TX_START: TX = 1'b0;
      TX_DATA:  TX = tx_shift_q[0];
      TX_STOP:  TXSENT = tx_cell_done && (tx_bit_q == STOP_LAST);
      default:  ;
    endcase
  end

  // tx_bit_q counts data bits in DATA and stop bits in STOP.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
    end else if (tx_state_q == TX_IDLE) begin
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
    end else if (tx_cell_done) begin
      tx_cnt_q <= '0;
      if (tx_state_q == TX_START || (tx_state_q == TX_DATA && tx_bit_q == DATA_LAST)) begin
        tx_bit_q <= '0;
      end else begin
        tx_bit_q <= tx_bit_q + 3'd1;
      end
    end else begin
      tx_cnt_q <= tx_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_hold_q <= '0;
    end else if (TXCAPTURE) begin
      tx_hold_q <= TXDATA;
    end
  end

  // Same-cycle capture+transmit bypasses the holding register.
  always_ff @(posedge CLK) begin
    if (tx_accept) begin
      tx_shift_q <= TXCAPTURE ? TXDATA : tx_hold_q;
    end else if (tx_state_q == TX_DATA && tx_cell_done) begin
      tx_shift_q <= {1'b0, tx_shift_q[DATA_BITS-1:1]};
    end
  end

  uart_ctrl_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk       (CLK),
    .rst_n     (RST),
    .rx        (RX),
    .byte_vld  (rx_byte_vld),
    .byte_data (rx_byte)
  );

  // A new good byte always wins over a same-cycle retrieve.
`ifdef UART_CTRL_OVERRUN_FLAG_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RXDATA       <= '0;
      RXDATA_READY <= 1'b0;
      RX_OVERRUN   <= 1'b0;
    end else if (rx_byte_vld) begin
      RXDATA       <= rx_byte;
      RXDATA_READY <= 1'b1;
      RX_OVERRUN   <= (RX_OVERRUN | RXDATA_READY) & ~RXDATA_RETRIEVED;
    end else if (RXDATA_RETRIEVED) begin
      RXDATA_READY <= 1'b0;
      RX_OVERRUN   <= 1'b0;
    end
  end
`else
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RXDATA       <= '0;
      RXDATA_READY <= 1'b0;
    end else if (rx_byte_vld) begin
      RXDATA       <= rx_byte;
      RXDATA_READY <= 1'b1;
    end else if (RXDATA_RETRIEVED) begin
      RXDATA_READY <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed self-checking bench for uart_ctrl (default build, 100 MHz, 115200 baud).
`timescale 1ns/1ps
module tb_uart_ctrl;

  localparam int BIT_CYC   = 868;
  localparam int FRAME_CYC = 10 * BIT_CYC;

  logic       CLK;
  logic       RST;
  logic       RX;
  logic       RXDATA_READY;
  logic       RXDATA_RETRIEVED;
  logic [7:0] RXDATA;
  logic       TX;
  logic [7:0] TXDATA;
  logic       TXCAPTURE;
  logic       TXTRANSMIT;
  logic       TXSENT;

  int n_checks = 0;
  int n_pass   = 0;

  uart_ctrl dut (
    .CLK              (CLK),
    .RST              (RST),
    .RX               (RX),
    .RXDATA_READY     (RXDATA_READY),
    .RXDATA_RETRIEVED (RXDATA_RETRIEVED),
    .RXDATA           (RXDATA),
    .TX               (TX),
    .TXDATA           (TXDATA),
    .TXCAPTURE        (TXCAPTURE),
    .TXTRANSMIT       (TXTRANSMIT),
    .TXSENT           (TXSENT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0;
    wait_cyc(BIT_CYC);
    for (int k = 0; k < 8; k++) begin
      RX = b[k];
      wait_cyc(BIT_CYC);
    end
    RX = stop_bit;
    wait_cyc(BIT_CYC);
    RX = 1'b1;
  endtask

  task automatic retrieve();
    RXDATA_RETRIEVED = 1'b1;
    wait_cyc(1);
    RXDATA_RETRIEVED = 1'b0;
  endtask

  // Entered 1 ns after the edge that accepted TXTRANSMIT (i = 0 is the first START cycle).
  task automatic tx_frame(input logic [7:0] exp_byte, input bit overlap, input bit chain,
                          input bit chain_cap, input logic [7:0] chain_data);
    int   sent_cnt;
    int   sent_idx;
    int   k;
    logic exp_bit;
    sent_cnt = 0;
    sent_idx = -1;
    for (int i = 0; i <= FRAME_CYC; i++) begin
      if (i == 0) begin
        TXTRANSMIT = 1'b0;
        TXCAPTURE  = 1'b0;
        check("tx_start_low", 32'(TX), 32'(0));
      end
      if ((i % BIT_CYC) == BIT_CYC / 2 && i < FRAME_CYC) begin
        k = i / BIT_CYC;
        if (k == 0) exp_bit = 1'b0;
        else if (k == 9) exp_bit = 1'b1;
        else exp_bit = exp_byte[k-1];
        check($sformatf("tx_bit%0d_byte%0h", k, exp_byte), 32'(TX), 32'(exp_bit));
      end
      if (TXSENT) begin
        sent_cnt = sent_cnt + 1;
        if (sent_idx < 0) sent_idx = i;
      end
      if (overlap && i == 2000) begin
        TXDATA     = 8'h55;
        TXCAPTURE  = 1'b1;
        TXTRANSMIT = 1'b1;
      end
      if (overlap && i == 2001) begin
        TXCAPTURE  = 1'b0;
        TXTRANSMIT = 1'b0;
        TXDATA     = 8'h00;
      end
      if (i == FRAME_CYC) begin
        check("tx_idle_after_frame", 32'(TX), 32'(1));
        if (chain) begin
          TXTRANSMIT = 1'b1;
          TXCAPTURE  = chain_cap;
          TXDATA     = chain_data;
        end
      end
      @(posedge CLK);
      #1;
    end
    check("txsent_count", 32'(sent_cnt), 32'(1));
    check("txsent_position", 32'(sent_idx), 32'(FRAME_CYC - 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST              = 1'b0;
    RX               = 1'b0;
    RXDATA_RETRIEVED = 1'b0;
    TXDATA           = 8'h00;
    TXCAPTURE        = 1'b0;
    TXTRANSMIT       = 1'b0;
    wait_cyc(5);
    check("rst_tx", 32'(TX), 32'(1));
    check("rst_txsent", 32'(TXSENT), 32'(0));
    check("rst_ready", 32'(RXDATA_READY), 32'(0));
    check("rst_rxdata", 32'(RXDATA), 32'h00);
    RST = 1'b1;

    // Line held low out of reset, then high, then a real 0x41 frame.
    wait_cyc(600);
    RX = 1'b1;
    wait_cyc(400);
    check("held_low_no_byte", 32'(RXDATA_READY), 32'(0));
    send_frame(8'h41, 1'b1);
    check("rx41_ready", 32'(RXDATA_READY), 32'(1));
    check("rx41_data", 32'(RXDATA), 32'h41);
    retrieve();
    check("rx41_retrieved", 32'(RXDATA_READY), 32'(0));

    // Framing error: byte discarded, previous data kept.
    wait_cyc(100);
    send_frame(8'h93, 1'b0);
    wait_cyc(600);
    check("frame_err_ready", 32'(RXDATA_READY), 32'(0));
    check("frame_err_data", 32'(RXDATA), 32'h41);

    // False start glitch followed closely by a valid frame.
    RX = 1'b0;
    wait_cyc(200);
    RX = 1'b1;
    wait_cyc(300);
    check("glitch_no_byte", 32'(RXDATA_READY), 32'(0));
    send_frame(8'h5A, 1'b1);
    check("rx5a_ready", 32'(RXDATA_READY), 32'(1));
    check("rx5a_data", 32'(RXDATA), 32'h5A);

    // 0x93 arrives while READY is still set: overwrite, READY held.
    wait_cyc(100);
    send_frame(8'h93, 1'b1);
    check("rx93_ready", 32'(RXDATA_READY), 32'(1));
    check("rx93_data", 32'(RXDATA), 32'h93);
    wait_cyc(200);
    check("rx93_ready_held", 32'(RXDATA_READY), 32'(1));
    retrieve();
    check("rx93_retrieved", 32'(RXDATA_READY), 32'(0));
    check("rx93_data_kept", 32'(RXDATA), 32'h93);

    // TX: capture 0xAA, transmit; mid-frame retransmit ignored, capture 0x55 held.
    TXDATA    = 8'hAA;
    TXCAPTURE = 1'b1;
    wait_cyc(1);
    TXCAPTURE  = 1'b0;
    TXDATA     = 8'h00;
    check("tx_idle_before", 32'(TX), 32'(1));
    TXTRANSMIT = 1'b1;
    wait_cyc(1);
    tx_frame(8'hAA, 1'b1, 1'b1, 1'b0, 8'h00);
    tx_frame(8'h55, 1'b0, 1'b1, 1'b1, 8'h3C);
    tx_frame(8'h3C, 1'b0, 1'b0, 1'b0, 8'h00);

    // Reset in the middle of a frame forces TX high and clears RX state.
    TXTRANSMIT = 1'b1;
    wait_cyc(1);
    TXTRANSMIT = 1'b0;
    wait_cyc(1000);
    check("tx_low_before_rst", 32'(TX), 32'(0));
    RST = 1'b0;
    #1;
    check("rst_mid_tx", 32'(TX), 32'(1));
    check("rst_mid_rxdata", 32'(RXDATA), 32'h00);
    check("rst_mid_ready", 32'(RXDATA_READY), 32'(0));
    wait_cyc(3);
    RST = 1'b1;
    wait_cyc(20);
    check("post_rst_tx", 32'(TX), 32'(1));
    check("post_rst_txsent", 32'(TXSENT), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
